// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: one WIDTH/STAGES-bit slice per stage, carry registered between stages.
// Optional overflow flag pipeline enabled by defining PIPELINED_ADDER_OVERFLOW_EN.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_cin,
  input  logic             io_sub,
  input  logic             io_signed,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_sum,
  output logic             io_cout,
  output logic             io_overflow
);

  localparam int SW = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be an integer multiple of STAGES");
  end

  logic advance;

  // A stalled output freezes every stage, so the whole pipe moves in lockstep.
  assign io_in_ready = !(io_out_valid && !io_out_ready);
  assign advance     = io_in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, eb_in, s_in, s_d;
    logic             c_in, v_in;
    logic [WIDTH-1:0] a_q, eb_q, s_q;
    logic             c_q, v_q;
    logic [SW:0]      slice;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic             sub_in, sgn_in, sub_q, sgn_q;
`endif

    if (k == 0) begin : g_head
      assign a_in  = io_a;
      assign eb_in = io_sub ? ~io_b : io_b;
      assign s_in  = {WIDTH{1'b0}};
      assign c_in  = io_sub ? 1'b1 : io_cin;
      assign v_in  = io_in_valid;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      assign sub_in = io_sub;
      assign sgn_in = io_signed;
`endif
    end else begin : g_link
      assign a_in  = g_stage[k-1].a_q;
      assign eb_in = g_stage[k-1].eb_q;
      assign s_in  = g_stage[k-1].s_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      assign sub_in = g_stage[k-1].sub_q;
      assign sgn_in = g_stage[k-1].sgn_q;
`endif
    end

    assign slice = {1'b0, a_in[k*SW +: SW]} + {1'b0, eb_in[k*SW +: SW]} + {{SW{1'b0}}, c_in};

    // Merge this stage's sum slice into the partial result carried down the pipe.
    always_comb begin
      s_d              = s_in;
      s_d[k*SW +: SW]  = slice[SW-1:0];
    end

    // Stage register: operands, partial sum, slice carry and valid advance together.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        a_q  <= {WIDTH{1'b0}};
        eb_q <= {WIDTH{1'b0}};
        s_q  <= {WIDTH{1'b0}};
        c_q  <= 1'b0;
        v_q  <= 1'b0;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        sub_q <= 1'b0;
        sgn_q <= 1'b0;
`endif
      end else if (advance) begin
        a_q  <= a_in;
        eb_q <= eb_in;
        s_q  <= s_d;
        c_q  <= slice[SW];
        v_q  <= v_in;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        sub_q <= sub_in;
        sgn_q <= sgn_in;
`endif
      end
    end
  end

  assign io_out_valid = g_stage[STAGES-1].v_q;
  assign io_sum       = g_stage[STAGES-1].s_q;
  assign io_cout      = g_stage[STAGES-1].c_q;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic ovf_d, ovf_q;
  logic unused_tail;

  // Overflow is resolved alongside the top slice so it lands in the same output register.
  always_comb begin
    if (g_stage[STAGES-1].sgn_in) begin
      ovf_d = (g_stage[STAGES-1].a_in[WIDTH-1] == g_stage[STAGES-1].eb_in[WIDTH-1]) &&
              (g_stage[STAGES-1].s_d[WIDTH-1]  != g_stage[STAGES-1].a_in[WIDTH-1]);
    end else begin
      ovf_d = g_stage[STAGES-1].slice[SW] ^ g_stage[STAGES-1].sub_in;
    end
  end

  // Output overflow register, held with the rest of the pipe during a stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign io_overflow = ovf_q;
  assign unused_tail = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].eb_q,
                         g_stage[STAGES-1].sub_q, g_stage[STAGES-1].sgn_q};
`else
  logic unused_tail;

  assign io_overflow = 1'b0;
  assign unused_tail = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].eb_q, io_signed};
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=2): directed steps, stall, reset and a random mixed-mode burst.
module tb_pipelined_adder;
  localparam int W = 8;
  localparam int S = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, sgn, cout, ovf;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   accepted;
  exp_t held;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready),
    .io_a(a), .io_b(b), .io_cin(cin), .io_sub(sub), .io_signed(sgn),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_sum(sum), .io_cout(cout), .io_overflow(ovf)
  );

  always #5 clock = ~clock;

  // Integer-arithmetic reference: true signed / unsigned range checks.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub, input logic msgn);
    exp_t e;
    int   ua, ub, ru, sa, sbv, rs;
    ua  = int'(ma);
    ub  = int'(mb);
    sa  = int'($signed(ma));
    sbv = int'($signed(mb));
    ru  = msub ? (ua - ub) : (ua + ub + int'(mcin));
    rs  = msub ? (sa - sbv) : (sa + sbv + int'(mcin));
    e.sum  = ru[W-1:0];
    e.cout = msub ? (ua >= ub) : (ru > 255);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    e.ovf  = msgn ? ((rs > 127) || (rs < -128)) : (msub ? (ua < ub) : (ru > 255));
`else
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dcin, input logic dsub, input logic dsgn);
    in_valid = 1'b1;
    a = da; b = db; cin = dcin; sub = dsub; sgn = dsgn;
  endtask

  // One clock: record input transfer, score output transfer, then step past the edge.
  task automatic tick();
    exp_t e;
    accepted = 1'b0;
    @(negedge clock);
    if (in_valid && in_ready) begin
      sb.push_back(model(a, b, cin, sub, sgn));
      accepted = 1'b1;
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed sum=0x%0h expected=no result", sum);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sum",      32'(sum),  32'(e.sum));
        check("cout",     32'(cout), 32'(e.cout));
        check("overflow", 32'(ovf),  32'(e.ovf));
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit done;
    in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0; sgn = 1'b0;

    // Reset state, sampled while reset is held
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_overflow",  32'(ovf),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Unsigned carry out of 0xFF + 0x01, with latency check
    drive(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("latency_cycle1_valid", 32'(out_valid), 32'd0);
    tick();
    check("latency_cycle2_valid", 32'(out_valid), 32'd1);
    tick();

    // Signed add overflow followed by unsigned borrow, back to back
    drive(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    tick();
    drive(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Ten back-to-back inputs, results must stream one per cycle
    for (int i = 0; i < 12; i++) begin
      if (i < 10) drive(8'(i), 8'(i), 1'b1, 1'b0, 1'b0);
      else        in_valid = 1'b0;
      tick();
      if (i >= 1 && i <= 10) check("stream_valid", 32'(out_valid), 32'd1);
    end
    check("stream_end_valid", 32'(out_valid), 32'd0);

    // Stall with output blocked for five cycles
    out_ready = 1'b0;
    drive(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h90, 8'h90, 1'b0, 1'b0, 1'b1);
    tick();
    drive(8'h03, 8'h09, 1'b1, 1'b1, 1'b1);
    held = sb[0];
    for (int n = 0; n < 5; n++) begin
      tick();
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum",       32'(sum),       32'(held.sum));
      check("stall_cout",      32'(cout),      32'(held.cout));
      check("stall_overflow",  32'(ovf),       32'(held.ovf));
    end
    out_ready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      tick();
      if (accepted) done = 1'b1;
    end
    check("stall_third_accepted", 32'(done), 32'd1);
    in_valid = 1'b0;
    repeat (4) tick();

    // Random mixed modes with random backpressure
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) != 0)
        drive(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else
        in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);

    // Reset with two operations in flight
    drive(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum",       32'(sum),       32'd0);
    check("mid_rst_overflow",  32'(ovf),       32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    check("final_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
